dht11_responder: RTL and testbench

Synthesizable DHT11 sensor emulator: the responder side of the single-wire DHT11 protocol that the DHT11 controller initiates. It watches the open-drain `dht11_io` line for a host start pulse, then drives the standard acknowledge and 40-bit frame built from the programmed humidity and temperature values. It is used for board-level loopback (controller and responder on the same FPGA) and for simulation without a physical sensor.

---
 rtl/dht11_responder.sv | 159 +++++++++++++++
 tb/tb_dht11_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: waits for a host start pulse on the open-drain line,
// then answers with the acknowledge and the 40-bit humidity/temperature frame.
module dht11_responder #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned START_MIN_US  = 18000,
  parameter int unsigned RESP_DELAY_US = 30,
  parameter int unsigned ACK_US        = 80,
  parameter int unsigned BIT_LOW_US    = 50,
  parameter int unsigned ZERO_HIGH_US  = 26,
  parameter int unsigned ONE_HIGH_US   = 70
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rh_int,
  input  logic [7:0] i_rh_dec,
  input  logic [7:0] i_temp_int,
  input  logic [7:0] i_temp_dec,
  inout  wire        dht11_io,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic [7:0] o_checksum
);

  localparam int unsigned DIV = CLK_FREQ / 1_000_000;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [15:0]   START_MIN  = 16'(START_MIN_US);
  localparam logic [15:0]   RESP_LAST  = 16'(RESP_DELAY_US - 1);
  localparam logic [15:0]   ACK_LAST   = 16'(ACK_US - 1);
  localparam logic [15:0]   LOW_LAST   = 16'(BIT_LOW_US - 1);
  localparam logic [15:0]   ZERO_LAST  = 16'(ZERO_HIGH_US - 1);
  localparam logic [15:0]   ONE_LAST   = 16'(ONE_HIGH_US - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HOST_LOW, S_WAIT_RESP, S_ACK_LOW, S_ACK_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_END_LOW, S_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [1:0]    sync_q;
  logic [1:0]    sync_vld;
  logic          line_s;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt;
  logic          tick;
  logic          adv;
  logic          drive_en;
  logic [39:0]   frame_sr;
  logic [5:0]    bit_idx;
  logic [7:0]    checksum_next;

  assign dht11_io      = drive_en ? 1'b0 : 1'bz;
  assign line_s        = sync_q[1];
  assign tick          = (presc == PRESC_LAST);
  assign checksum_next = i_rh_int + i_rh_dec + i_temp_int + i_temp_dec;

  // sync_vld masks the reset value of the synchronizer until a real sample arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      sync_vld <= '0;
    end else begin
      sync_q   <= {sync_q[0], dht11_io};
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  always_comb begin
    adv = 1'b0;
    unique case (state)
      S_IDLE:      adv = sync_vld[1] && !line_s;
      S_HOST_LOW:  adv = line_s;
      S_WAIT_RESP: adv = tick && (us_cnt == RESP_LAST);
      S_ACK_LOW:   adv = tick && (us_cnt == ACK_LAST);
      S_ACK_HIGH:  adv = tick && (us_cnt == ACK_LAST);
      S_BIT_LOW:   adv = tick && (us_cnt == LOW_LAST);
      S_BIT_HIGH:  adv = tick && (us_cnt == (frame_sr[39] ? ONE_LAST : ZERO_LAST));
      S_END_LOW:   adv = tick && (us_cnt == LOW_LAST);
      S_WAIT_IDLE: adv = line_s;
      default:     adv = 1'b0;
    endcase
  end

  // Every state change restarts the timebase so each phase is an exact cycle count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      presc        <= '0;
      us_cnt       <= '0;
      drive_en     <= 1'b0;
      frame_sr     <= '0;
      bit_idx      <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_checksum   <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (adv) begin
        presc  <= '0;
        us_cnt <= '0;
        unique case (state)
          S_IDLE: state <= S_HOST_LOW;
          S_HOST_LOW: begin
            if (us_cnt >= START_MIN) begin
              frame_sr   <= {i_rh_int, i_rh_dec, i_temp_int, i_temp_dec, checksum_next};
              o_checksum <= checksum_next;
              o_busy     <= 1'b1;
              state      <= S_WAIT_RESP;
            end else begin
              state <= S_IDLE;
            end
          end
          S_WAIT_RESP: begin
            drive_en <= 1'b1;
            state    <= S_ACK_LOW;
          end
          S_ACK_LOW: begin
            drive_en <= 1'b0;
            state    <= S_ACK_HIGH;
          end
          S_ACK_HIGH: begin
            drive_en <= 1'b1;
            bit_idx  <= 6'd39;
            state    <= S_BIT_LOW;
          end
          S_BIT_LOW: begin
            drive_en <= 1'b0;
            state    <= S_BIT_HIGH;
          end
          S_BIT_HIGH: begin
            drive_en <= 1'b1;
            frame_sr <= {frame_sr[38:0], 1'b0};
            if (bit_idx == 6'd0) begin
              state <= S_END_LOW;
            end else begin
              bit_idx <= bit_idx - 6'd1;
              state   <= S_BIT_LOW;
            end
          end
          S_END_LOW: begin
            drive_en     <= 1'b0;
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state        <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: state <= S_IDLE;
          default:     state <= S_IDLE;
        endcase
      end else if (tick) begin
        presc <= '0;
        if (us_cnt != '1) us_cnt <= us_cnt + 16'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: plays the host side of the bus and
// decodes the acknowledge and frame from sampled pulse widths.
`timescale 1ns/1ps
module tb_dht11_responder;

  localparam int unsigned CLK_FREQ  = 2_000_000;
  localparam int          DIV       = 2;
  localparam int unsigned START_MIN = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rh_int = '0, rh_dec = '0, t_int = '0, t_dec = '0;
  logic       host_low = 1'b0;
  wire        bus;
  logic       busy, frame_done;
  logic [7:0] cs;
  int         checks = 0;
  int         failures = 0;
  int         fd_cnt = 0;

  pullup (bus);
  assign bus = host_low ? 1'b0 : 1'bz;

  dht11_responder #(
    .CLK_FREQ(CLK_FREQ),
    .START_MIN_US(START_MIN)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .i_rh_int(rh_int),
    .i_rh_dec(rh_dec),
    .i_temp_int(t_int),
    .i_temp_dec(t_dec),
    .dht11_io(bus),
    .o_busy(busy),
    .o_frame_done(frame_done),
    .o_checksum(cs)
  );

  always #250 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #(200_000 * 500);
    $display("FAIL watchdog: simulation exceeded 200000 cycles");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  rh_i, rh_d, t_i, t_d;
    int          start_us;
    logic        exp_resp;
    logic [39:0] exp_frame;
    logic [7:0]  exp_cs;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (bus === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic host_start(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * DIV) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic run_frame(input int start_us, input logic exp_resp, input logic [39:0] exp_frame,
                           input logic [7:0] exp_cs, input int chg_bit, input int abort_bit);
    int n, bad, lo, hi, fd0;
    logic [39:0] got;
    fd0 = fd_cnt;
    host_start(start_us);
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_latency", busy, 0);
    @(negedge clk);
    chk("busy_latency", busy, exp_resp);
    chk("checksum", cs, exp_cs);
    if (!exp_resp) begin
      bad = 0;
      for (int i = 0; i < 400; i++) begin
        if (bus !== 1'b1 || busy !== 1'b0) bad++;
        @(negedge clk);
      end
      chk("short_start_quiet", bad, 0);
      chk("short_start_no_done", fd_cnt - fd0, 0);
      return;
    end
    n = 3;
    while (bus !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("resp_delay_cycles", n, 3 + 30 * DIV);
    if (n >= 1000) return;
    measure(1'b0, lo);
    chk("ack_low", lo, 80 * DIV);
    measure(1'b1, hi);
    chk("ack_high", hi, 80 * DIV);
    got = '0;
    bad = 0;
    for (int b = 0; b < 40; b++) begin
      if (b == chg_bit) t_int = 8'd99;
      if (b == abort_bit) begin
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_bus_released", bus, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_checksum", cs, 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_no_done", fd_cnt - fd0, 0);
        chk("reset_idle_quiet", {busy, bus}, 2'b01);
        return;
      end
      measure(1'b0, lo);
      measure(1'b1, hi);
      if (lo != 50 * DIV) bad++;
      if (hi == 70 * DIV) got = {got[38:0], 1'b1};
      else begin
        got = {got[38:0], 1'b0};
        if (hi != 26 * DIV) bad++;
      end
      if (bad > 3) break;
    end
    chk("bit_width_errors", bad, 0);
    chk("frame_data", got, exp_frame);
    measure(1'b0, lo);
    chk("end_low", lo, 50 * DIV);
    chk("done_pulse", frame_done, 1);
    chk("busy_clear", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", frame_done, 0);
    chk("done_count", fd_cnt - fd0, 1);
    repeat (10) @(negedge clk);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{8'd55, 8'd0, 8'd24, 8'd0, 150, 1'b1, 40'h37_00_18_00_4F, 8'h4F};
    vecs[1] = '{8'd1, 8'd2, 8'd3, 8'd4, 60, 1'b0, 40'h0, 8'h4F};
    vecs[2] = '{8'hFF, 8'hFF, 8'h02, 8'h01, 150, 1'b1, 40'hFF_FF_02_01_01, 8'h01};
    vecs[3] = '{8'hA5, 8'h5A, 8'h0F, 8'hF0, 102, 1'b1, 40'hA5_5A_0F_F0_FE, 8'hFE};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 98, 1'b0, 40'h0, 8'hFE};

    #1;
    chk("rst_bus", bus, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_checksum", cs, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_quiet", {busy, bus}, 2'b01);

    for (int v = 0; v < 5; v++) begin
      rh_int = vecs[v].rh_i;
      rh_dec = vecs[v].rh_d;
      t_int  = vecs[v].t_i;
      t_dec  = vecs[v].t_d;
      run_frame(vecs[v].start_us, vecs[v].exp_resp, vecs[v].exp_frame, vecs[v].exp_cs, -1, -1);
    end

    // Input change during bit 10 must not disturb the frame in flight.
    rh_int = 8'd55; rh_dec = 8'd0; t_int = 8'd24; t_dec = 8'd0;
    run_frame(150, 1'b1, 40'h37_00_18_00_4F, 8'h4F, 10, -1);
    run_frame(150, 1'b1, 40'h37_00_63_00_9A, 8'h9A, -1, -1);

    // Reset during bit 20, then a clean frame.
    rh_int = 8'h12; rh_dec = 8'h34; t_int = 8'h56; t_dec = 8'h78;
    run_frame(150, 1'b1, 40'h12_34_56_78_14, 8'h14, -1, 20);
    run_frame(150, 1'b1, 40'h12_34_56_78_14, 8'h14, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
